// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first: synchronises the raw line, rejects short start
// glitches and presents each well-framed byte with a one-cycle rx_down strobe.
module uart_byte_rx #(
    parameter int BAUD_DIV = 5208,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] po_data,
    output logic       rx_down,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [CW-1:0] r_baud_cnt, w_baud_nxt;
    logic [2:0]    r_bit_cnt, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_po_data, w_data_nxt;
    logic          r_rx_down, w_rx_down_nxt;
    logic          r_frame_err, w_frame_err_nxt;
    logic          r_rx_busy, w_busy_nxt;
    logic          w_start_edge;

    assign w_start_edge = r_rx_s3 & ~r_rx_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle level so release cannot fake a start edge.
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_s3     <= 1'b1;
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_po_data   <= '0;
            r_rx_down   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_rx_s1     <= rs232_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_s3     <= r_rx_s2;
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_po_data   <= w_data_nxt;
            r_rx_down   <= w_rx_down_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_rx_busy   <= w_busy_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = r_baud_cnt + 1'b1;
        w_bit_nxt       = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_po_data;
        w_rx_down_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_start_edge) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_rx_s2, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                    else                   w_bit_nxt   = r_bit_cnt + 3'd1;
                end
            end
            S_STOP: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    if (r_rx_s2) begin
                        w_data_nxt    = r_shift;
                        w_rx_down_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign po_data   = r_po_data;
    assign rx_down   = r_rx_down;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_rx_busy;

endmodule
